// File: rtl/chip8_ram_arbiter_pkg.sv
// Shared types and constants for the chip8_ram read-port arbiter.
// Owner tags travel alongside each in-flight RAM read.
package chip8_arb_pkg;

  localparam int unsigned TAG_W      = 2;
  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [TAG_W-1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_REN  = 2'd2,
    TAG_CPU  = 2'd3
  } tag_e;

  // Saturating +1 for the 16-bit wait statistics.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/chip8_ram_arbiter_if.sv
// Requester/RAM read bus of the chip8_ram arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface chip8_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;

  logic              ren_req;
  logic [ADDR_W-1:0] ren_addr;
  logic              ren_gnt;
  logic              ren_rvalid;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_read_address;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  vid_req, vid_addr, ren_req, ren_addr, cpu_req, cpu_addr, ram_q,
    output vid_gnt, vid_rvalid, ren_gnt, ren_rvalid, cpu_gnt, cpu_rvalid,
           rdata, ram_read_address
  );

  modport master (
    output vid_req, vid_addr, ren_req, ren_addr, cpu_req, cpu_addr, ram_q,
    input  vid_gnt, vid_rvalid, ren_gnt, ren_rvalid, cpu_gnt, cpu_rvalid,
           rdata, ram_read_address
  );

endinterface

// File: rtl/chip8_ram_arbiter_tag_pipe.sv
// Owner-tag delay line matching the RAM read latency; the last stage
// names the requester that owns ram_q in the current cycle.
module chip8_arb_tag_pipe
  import chip8_arb_pkg::*;
#(
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_e i_tag,
  output tag_e o_tag
);

  tag_e r_pipe [RAM_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
        r_pipe[i] <= TAG_NONE;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[RAM_LATENCY-1];

endmodule

// File: rtl/chip8_ram_arbiter.sv
// Read-port arbiter for chip8_ram: vid fixed priority, ren/cpu round-robin,
// owner-tagged return path. Optional wait statistics: CHIP8_ARB_STATS_EN.
module chip8_ram_arbiter
  import chip8_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  chip8_ram_arbiter_if.slave  bus
`ifdef CHIP8_ARB_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         cpu_wait_cnt,
  output logic [15:0]         ren_wait_cnt
`endif
);

  // r_last_rr = 1 means ren was served last, so cpu wins the next tie.
  logic              r_last_rr;
  logic [ADDR_W-1:0] r_addr;

  logic              w_vid_gnt;
  logic              w_ren_gnt;
  logic              w_cpu_gnt;
  tag_e              w_gnt_tag;
  tag_e              w_out_tag;
  logic [ADDR_W-1:0] w_gnt_addr;

  // Reset participates here so no grant can leak out while it is asserted.
  always_comb begin
    w_vid_gnt = 1'b0;
    w_ren_gnt = 1'b0;
    w_cpu_gnt = 1'b0;
    if (!reset) begin
      if (bus.vid_req) begin
        w_vid_gnt = 1'b1;
      end else if (bus.ren_req && bus.cpu_req) begin
        if (r_last_rr) w_cpu_gnt = 1'b1;
        else           w_ren_gnt = 1'b1;
      end else if (bus.ren_req) begin
        w_ren_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        w_cpu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt_tag  = TAG_NONE;
    w_gnt_addr = r_addr;
    if (w_vid_gnt) begin
      w_gnt_tag  = TAG_VID;
      w_gnt_addr = bus.vid_addr;
    end else if (w_ren_gnt) begin
      w_gnt_tag  = TAG_REN;
      w_gnt_addr = bus.ren_addr;
    end else if (w_cpu_gnt) begin
      w_gnt_tag  = TAG_CPU;
      w_gnt_addr = bus.cpu_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_rr <= 1'b0;
      r_addr    <= '0;
    end else begin
      if (w_ren_gnt)      r_last_rr <= 1'b1;
      else if (w_cpu_gnt) r_last_rr <= 1'b0;
      if (w_gnt_tag != TAG_NONE) r_addr <= w_gnt_addr;
    end
  end

  chip8_arb_tag_pipe #(
    .RAM_LATENCY (RAM_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_gnt_tag),
    .o_tag (w_out_tag)
  );

  assign bus.vid_gnt          = w_vid_gnt;
  assign bus.ren_gnt          = w_ren_gnt;
  assign bus.cpu_gnt          = w_cpu_gnt;
  assign bus.ram_read_address = w_gnt_addr;
  assign bus.vid_rvalid       = (w_out_tag == TAG_VID);
  assign bus.ren_rvalid       = (w_out_tag == TAG_REN);
  assign bus.cpu_rvalid       = (w_out_tag == TAG_CPU);
  assign bus.rdata            = bus.ram_q;

`ifdef CHIP8_ARB_STATS_EN
  logic [15:0] r_cpu_wait;
  logic [15:0] r_ren_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_wait <= '0;
      r_ren_wait <= '0;
    end else if (stats_clr) begin
      r_cpu_wait <= '0;
      r_ren_wait <= '0;
    end else begin
      if (bus.cpu_req && !w_cpu_gnt) r_cpu_wait <= sat_inc16(r_cpu_wait);
      if (bus.ren_req && !w_ren_gnt) r_ren_wait <= sat_inc16(r_ren_wait);
    end
  end

  assign cpu_wait_cnt = r_cpu_wait;
  assign ren_wait_cnt = r_ren_wait;
`endif

endmodule
